// File: rtl/audio_pkg.sv
// Constants and types shared along the audio sample path (tone generator -> I2S serializer).
// Divider defaults live here so the tone generator's note math and the DAC sample rate agree.
package audio_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int FRAME_SLOTS       = 32;
  localparam int FRAME_W           = 2 * SAMPLE_W;
  localparam int SLOT_IDX_W        = $clog2(FRAME_SLOTS);
  localparam int MCLK_DIV_LOG2_DEF = 2;
  localparam int SCLK_DIV_LOG2_DEF = 4;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter producing mclk/sclk/lrck as direct register bits (glitch-free),
// plus the slot index and the one-cycle-early slot_start / frame_wrap strobes.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int MCLK_DIV_LOG2 = MCLK_DIV_LOG2_DEF,
  parameter int SCLK_DIV_LOG2 = SCLK_DIV_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mclk,
  output logic                  sclk,
  output logic                  lrck,
  output logic [SLOT_IDX_W-1:0] slot,
  output logic                  slot_start,
  output logic                  frame_wrap
);

  localparam int CNT_W = SCLK_DIV_LOG2 + SLOT_IDX_W;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mclk = cnt_q[MCLK_DIV_LOG2-1];
  assign sclk = cnt_q[SCLK_DIV_LOG2-1];
  assign lrck = cnt_q[CNT_W-1];
  assign slot = cnt_q[CNT_W-1:SCLK_DIV_LOG2];

  // Both strobes flag the cycle *before* the wrap, so the consuming flop updates on the wrap edge.
  assign slot_start = &cnt_q[SCLK_DIV_LOG2-1:0];
  assign frame_wrap = &cnt_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S serializer: latches {left,right} once per frame and shifts it MSB-first with a one-slot delay.
// MSB on sdin 2^SCLK_DIV_LOG2 clk after the latch; no backpressure, samples must be valid at sample_req.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int MCLK_DIV_LOG2 = MCLK_DIV_LOG2_DEF,
  parameter int SCLK_DIV_LOG2 = SCLK_DIV_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  output logic                sample_req,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdin
);

  logic [SLOT_IDX_W-1:0] slot;
  logic                  slot_start;
  logic                  frame_wrap;

  i2s_clk_gen #(
    .MCLK_DIV_LOG2(MCLK_DIV_LOG2),
    .SCLK_DIV_LOG2(SCLK_DIV_LOG2)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .mclk      (mclk),
    .sclk      (sclk),
    .lrck      (lrck),
    .slot      (slot),
    .slot_start(slot_start),
    .frame_wrap(frame_wrap)
  );

  frame_t                frame_q;
  frame_t                frame_d;
  logic                  sdin_q;
  logic                  sdin_d;
  logic [FRAME_W-1:0]    frame_bits;
  logic [SLOT_IDX_W-1:0] bit_idx;

  assign frame_bits = frame_q;
  // Slot s+1 carries W[31-s]; at s = 31 this is W[0] of the frame still held, ahead of the reload.
  assign bit_idx    = ~slot;

  always_comb begin
    frame_d = frame_q;
    sdin_d  = sdin_q;
    if (frame_wrap) begin
      frame_d = '{left: audio_left, right: audio_right};
    end
    if (slot_start) begin
      sdin_d = frame_bits[bit_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      sdin_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      sdin_q  <= sdin_d;
    end
  end

  assign sdin       = sdin_q;
  assign sample_req = frame_wrap;

endmodule
